// File: rtl/digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// digit_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit display. It steps a 2-bit
// digit select through slots 0..3. Each slot starts with a blanking window
// in which the decoder enable is held low to suppress ghosting. Display
// values are double-buffered. A load goes into a shadow register and is
// copied to the active register only at a frame start, so one frame never
// mixes digits from two different values.
//
// Parameters:
//   DWELL      - clock cycles per digit slot, blanking included (2..65535)
//   BLANK      - blanking cycles at the start of each slot (1..DWELL-1)
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   run        - level: 1 = scanning, 0 = idle
//   load       - single-cycle strobe: capture data_in into the shadow register
//   data_in    - 16-bit display value, digit k = data_in[4k+3:4k]
//   sel        - digit select code to the 2-to-4 decoder
//   sel_en     - decoder enable, low during blanking and idle
//   nibble     - active digit for the current sel, valid while sel_en=1
//   frame_done - one-cycle pulse when slot 3 wraps to slot 0
//   load_ack   - one-cycle pulse when shadow is copied to active
// ---------------------------------------------------------------------------
module digit_scan_ctrl #(
    parameter int DWELL = 8,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] data_in,
    output logic [1:0]  sel,
    output logic        sel_en,
    output logic [3:0]  nibble,
    output logic        frame_done,
    output logic        load_ack
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        selEn_q, selEn_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        frameDone_q, frameDone_d;
    logic        loadAck_q, loadAck_d;
    logic [15:0] active_q, active_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;

    // Asserted for the cycle that leads into a frame start or a slot start
    logic        frameStart;
    logic        slotStart;

    // State and output registers. Reset is synchronous and clears every
    // register, a pending load included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            selEn_q     <= 1'b0;
            nibble_q    <= '0;
            frameDone_q <= 1'b0;
            loadAck_q   <= 1'b0;
            active_q    <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            selEn_q     <= selEn_d;
            nibble_q    <= nibble_d;
            frameDone_q <= frameDone_d;
            loadAck_q   <= loadAck_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
        end
    end

    // Next-state logic. The outputs are registered, so every value computed
    // here is what the outputs show in the cycle after the edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        selEn_d     = selEn_q;
        nibble_d    = nibble_q;
        frameDone_d = 1'b0;
        loadAck_d   = 1'b0;
        active_d    = active_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        frameStart  = 1'b0;
        slotStart   = 1'b0;

        if (!run) begin
            // Dropping run abandons the partial frame without a frame_done.
            state_d = IDLE;
            cnt_d   = '0;
            sel_d   = '0;
            selEn_d = 1'b0;
        end else if (state_q == IDLE) begin
            // Entering SCAN starts a new frame but is not a frame boundary.
            state_d    = SCAN;
            cnt_d      = '0;
            sel_d      = '0;
            selEn_d    = 1'b0;
            frameStart = 1'b1;
            slotStart  = 1'b1;
        end else if (cnt_q == 16'(DWELL - 1)) begin
            cnt_d     = '0;
            sel_d     = sel_q + 2'd1;
            selEn_d   = 1'b0;
            slotStart = 1'b1;
            if (sel_q == 2'd3) begin
                frameStart  = 1'b1;
                frameDone_d = 1'b1;
            end
        end else begin
            cnt_d   = cnt_q + 16'd1;
            selEn_d = (cnt_d >= 16'(BLANK));
        end

        // The transfer uses the shadow value held before this edge. A load
        // in the same cycle refills shadow and keeps pending set, so the
        // new value waits for the next frame start.
        if (frameStart && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            loadAck_d = 1'b1;
        end

        if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end

        // The nibble is latched during blanking from the post-transfer
        // value, so it is stable for the whole enabled window.
        if (slotStart) begin
            case (sel_d)
                2'd0:    nibble_d = active_d[3:0];
                2'd1:    nibble_d = active_d[7:4];
                2'd2:    nibble_d = active_d[11:8];
                default: nibble_d = active_d[15:12];
            endcase
        end
    end

    assign sel        = sel_q;
    assign sel_en     = selEn_q;
    assign nibble     = nibble_q;
    assign frame_done = frameDone_q;
    assign load_ack   = loadAck_q;

endmodule
